// File: rtl/alu_pkg.sv
// Shared definitions for the 8085 ALU/flag stage: opcodes, flag layout, flag packing.
package alu_pkg;

    localparam int unsigned OP_BITS = 5;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 5'd0,
        OP_ADC = 5'd1,
        OP_SUB = 5'd2,
        OP_SBB = 5'd3,
        OP_ANA = 5'd4,
        OP_XRA = 5'd5,
        OP_ORA = 5'd6,
        OP_CMP = 5'd7,
        OP_INR = 5'd8,
        OP_DCR = 5'd9,
        OP_RLC = 5'd10,
        OP_RRC = 5'd11,
        OP_RAL = 5'd12,
        OP_RAR = 5'd13,
        OP_DAA = 5'd14,
        OP_CMA = 5'd15,
        OP_STC = 5'd16,
        OP_CMC = 5'd17
    } alu_op_e;

    // Bit positions of the flags within the PSW flag byte.
    localparam int unsigned F_S  = 7;
    localparam int unsigned F_Z  = 6;
    localparam int unsigned F_AC = 4;
    localparam int unsigned F_P  = 2;
    localparam int unsigned F_CY = 0;

    typedef struct packed {
        logic s;
        logic z;
        logic ac;
        logic p;
        logic cy;
    } flags_t;

    // Flag byte as seen on the bus: {S,Z,0,AC,0,P,1,CY}.
    function automatic logic [7:0] flags_to_byte(input flags_t f);
        return {f.s, f.z, 1'b0, f.ac, 1'b0, f.p, 1'b1, f.cy};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 8085 ALU: result, next flags and accumulator-write enable.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned W_OP = 5
) (
    input  logic [7:0]      a,
    input  logic [7:0]      b,
    input  logic [W_OP-1:0] op,
    input  flags_t          flags_in,
    output logic [7:0]      result,
    output flags_t          flags_next,
    output logic            wr
);

    logic [8:0] sum;
    logic [4:0] nib;
    logic       cin;
    logic [8:0] daa1;
    logic       daa_lo;
    logic       daa_hi;
    logic [7:0] fv;
    logic       szp_upd;
    logic       ac;
    logic       cy;

    // Decode op and compute the result plus the flag value each op defines.
    always_comb begin
        result  = a;
        fv      = a;
        wr      = 1'b0;
        szp_upd = 1'b0;
        ac      = flags_in.ac;
        cy      = flags_in.cy;
        sum     = '0;
        nib     = '0;
        cin     = 1'b0;
        daa1    = '0;
        daa_lo  = 1'b0;
        daa_hi  = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                cin     = (op == OP_ADC) & flags_in.cy;
                sum     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                nib     = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
                fv      = sum[7:0];
                result  = fv;
                cy      = sum[8];
                ac      = nib[4];
                wr      = 1'b1;
                szp_upd = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                cin     = (op == OP_SBB) ? ~flags_in.cy : 1'b1;
                sum     = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
                nib     = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'd0, cin};
                fv      = sum[7:0];
                result  = (op == OP_CMP) ? a : fv;
                cy      = ~sum[8];
                ac      = nib[4];
                wr      = (op != OP_CMP);
                szp_upd = 1'b1;
            end
            OP_ANA, OP_XRA, OP_ORA: begin
                fv      = (op == OP_ANA) ? (a & b) : (op == OP_XRA) ? (a ^ b) : (a | b);
                result  = fv;
                cy      = 1'b0;
                ac      = (op == OP_ANA);
                wr      = 1'b1;
                szp_upd = 1'b1;
            end
            OP_INR, OP_DCR: begin
                // DCR adds 0xFF so AC is the nibble carry of that addition.
                sum     = {1'b0, a} + ((op == OP_INR) ? 9'd1 : 9'h0FF);
                nib     = {1'b0, a[3:0]} + ((op == OP_INR) ? 5'd1 : 5'd15);
                fv      = sum[7:0];
                result  = fv;
                ac      = nib[4];
                wr      = 1'b1;
                szp_upd = 1'b1;
            end
            OP_RLC: begin result = {a[6:0], a[7]};        cy = a[7]; wr = 1'b1; end
            OP_RRC: begin result = {a[0], a[7:1]};        cy = a[0]; wr = 1'b1; end
            OP_RAL: begin result = {a[6:0], flags_in.cy}; cy = a[7]; wr = 1'b1; end
            OP_RAR: begin result = {flags_in.cy, a[7:1]}; cy = a[0]; wr = 1'b1; end
            OP_DAA: begin
                // High-nibble test uses the nibble after the low adjust; a carry
                // out of bit 7 from the low adjust also forces the high adjust.
                daa_lo  = (a[3:0] > 4'd9) | flags_in.ac;
                daa1    = {1'b0, a} + (daa_lo ? 9'd6 : 9'd0);
                nib     = {1'b0, a[3:0]} + (daa_lo ? 5'd6 : 5'd0);
                daa_hi  = (daa1[7:4] > 4'd9) | flags_in.cy | daa1[8];
                fv      = daa1[7:0] + (daa_hi ? 8'h60 : 8'h00);
                result  = fv;
                ac      = nib[4];
                cy      = flags_in.cy | daa_hi;
                wr      = 1'b1;
                szp_upd = 1'b1;
            end
            OP_CMA: begin result = ~a; wr = 1'b1; end
            OP_STC: cy = 1'b1;
            OP_CMC: cy = ~flags_in.cy;
            default: ;
        endcase
        flags_next.s  = szp_upd ? fv[7] : flags_in.s;
        flags_next.z  = szp_upd ? (fv == 8'h00) : flags_in.z;
        flags_next.p  = szp_upd ? ~^fv : flags_in.p;
        flags_next.ac = ac;
        flags_next.cy = cy;
    end

endmodule

// File: rtl/alu_flag_unit.sv
// 8085 ALU stage: TMP latch, registered result, flag register and its bus port.
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int unsigned W_OP = 5
) (
    input  logic            clk,
    input  logic            reset,
    inout  logic [7:0]      data_bus,
    input  logic [7:0]      acc_in,
    input  logic            tmp_load,
    input  logic [W_OP-1:0] op,
    input  logic            op_valid,
    input  logic            flag_rd,
    input  logic            flag_wr,
    output logic [7:0]      alu_data,
    output logic            res_valid,
    output logic            res_wr,
    output logic [7:0]      flags
);

    logic [7:0] tmp_q;
    flags_t     flag_q;
    flags_t     bus_flags;
    logic [7:0] core_result;
    flags_t     core_flags;
    logic       core_wr;

    alu_core #(.W_OP(W_OP)) u_core (
        .a          (acc_in),
        .b          (tmp_q),
        .op         (op),
        .flags_in   (flag_q),
        .result     (core_result),
        .flags_next (core_flags),
        .wr         (core_wr)
    );

    // Flag fields as written from the bus (PSW pop).
    assign bus_flags = {data_bus[F_S], data_bus[F_Z], data_bus[F_AC], data_bus[F_P], data_bus[F_CY]};

    assign flags = flags_to_byte(flag_q);

    // Drive the flag byte only for a pure read; a simultaneous write owns the bus.
    assign data_bus = (flag_rd && !flag_wr && !reset) ? flags : 'z;

    // TMP, result and flag registers; a bus write overrides op flag updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmp_q     <= '0;
            alu_data  <= '0;
            res_valid <= 1'b0;
            res_wr    <= 1'b0;
            flag_q    <= '0;
        end else begin
            res_valid <= op_valid;
            res_wr    <= op_valid & core_wr;
            if (op_valid)
                alu_data <= core_result;
            if (tmp_load)
                tmp_q <= data_bus;
            if (flag_wr)
                flag_q <= bus_flags;
            else if (op_valid)
                flag_q <= core_flags;
        end
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed spec cases plus random ops vs a reference model.
module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    wire  [7:0] bus;
    logic [7:0] tb_drv;
    logic       tb_en;
    logic [7:0] acc_in;
    logic       tmp_load;
    logic [4:0] op;
    logic       op_valid;
    logic       flag_rd;
    logic       flag_wr;
    logic [7:0] alu_data;
    logic       res_valid;
    logic       res_wr;
    logic [7:0] flags;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_tmp;
    logic [7:0] m_f;
    logic [7:0] m_res;

    assign bus = tb_en ? tb_drv : 8'hzz;

    always #5 clk = ~clk;

    alu_flag_unit #(.W_OP(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_bus  (bus),
        .acc_in    (acc_in),
        .tmp_load  (tmp_load),
        .op        (op),
        .op_valid  (op_valid),
        .flag_rd   (flag_rd),
        .flag_wr   (flag_wr),
        .alu_data  (alu_data),
        .res_valid (res_valid),
        .res_wr    (res_wr),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {wr, flag byte, result} from the instruction-set rules.
    function automatic logic [16:0] ref_op(input int opc, input int a, input int b, input logic [7:0] f);
        int r, v, t, c;
        bit s, z, ac, p, cy, wr, upd, lo, hi;
        s = f[7]; z = f[6]; ac = f[4]; p = f[2]; cy = f[0];
        r = a; v = a; wr = 0; upd = 0;
        case (opc)
            0, 1: begin
                c = (opc == 1) ? int'(cy) : 0;
                t = a + b + c;
                v = t % 256; r = v; cy = (t > 255);
                ac = ((a % 16) + (b % 16) + c) > 15;
                wr = 1; upd = 1;
            end
            2, 3, 7: begin
                c = (opc == 3) ? int'(cy) : 0;
                t = a - b - c;
                v = (t + 256) % 256;
                r = (opc == 7) ? a : v;
                cy = (t < 0);
                ac = ((a % 16) + 15 - (b % 16) + 1 - c) > 15;
                wr = (opc != 7); upd = 1;
            end
            4: begin v = a & b; r = v; cy = 0; ac = 1; wr = 1; upd = 1; end
            5: begin v = a ^ b; r = v; cy = 0; ac = 0; wr = 1; upd = 1; end
            6: begin v = a | b; r = v; cy = 0; ac = 0; wr = 1; upd = 1; end
            8: begin v = (a + 1) % 256;   r = v; ac = (a % 16 == 15); wr = 1; upd = 1; end
            9: begin v = (a + 255) % 256; r = v; ac = (a % 16 != 0);  wr = 1; upd = 1; end
            10: begin r = (a * 2) % 256 + a / 128;          cy = (a >= 128);   wr = 1; end
            11: begin r = a / 2 + (a % 2) * 128;            cy = (a % 2 == 1); wr = 1; end
            12: begin r = (a * 2) % 256 + int'(cy);         cy = (a >= 128);   wr = 1; end
            13: begin r = a / 2 + int'(cy) * 128;           cy = (a % 2 == 1); wr = 1; end
            14: begin
                lo = (a % 16 > 9) || ac;
                t  = a + (lo ? 6 : 0);
                ac = lo && ((a % 16) + 6 > 15);
                hi = (((t % 256) / 16) > 9) || cy || (t > 255);
                if (hi) begin t = t + 96; cy = 1; end
                v = t % 256; r = v; wr = 1; upd = 1;
            end
            15: begin r = 255 - a; wr = 1; end
            16: cy = 1;
            17: cy = !cy;
            default: ;
        endcase
        if (upd) begin
            s = (v >= 128);
            z = (v == 0);
            p = ($countones(v) % 2 == 0);
        end
        return {wr, s, z, 1'b0, ac, 1'b0, p, 1'b1, cy, 8'(r)};
    endfunction

    // One clock: apply inputs, advance the model, check every output.
    task automatic cycle(input bit ov, input int opc, input int a, input bit tl,
                         input bit fw, input bit fr, input int drv);
        logic [16:0] e;
        logic [7:0]  bus_val;
        op_valid = ov; op = 5'(opc); acc_in = 8'(a);
        tmp_load = tl; flag_wr = fw; flag_rd = fr;
        tb_en = !(fr && !fw); tb_drv = 8'(drv);
        bus_val = tb_en ? 8'(drv) : m_f;
        e = ref_op(opc, a, int'(m_tmp), m_f);
        @(posedge clk); #1;
        if (ov) m_res = e[7:0];
        if (tl) m_tmp = bus_val;
        if (fw) m_f = (bus_val & 8'hD5) | 8'h02;
        else if (ov) m_f = e[15:8];
        check("alu_data", alu_data, m_res);
        check("flags", flags, m_f);
        check("res_valid", {7'd0, res_valid}, {7'd0, ov});
        check("res_wr", {7'd0, res_wr}, {7'd0, ov & e[16]});
        if (fr && !fw) check("bus_read", bus, m_f);
        else           check("bus_release", bus, 8'(drv));
    endtask

    initial begin
        reset = 1'b1; op_valid = 0; op = '0; acc_in = '0; tmp_load = 0;
        flag_wr = 0; flag_rd = 1; tb_en = 1; tb_drv = 8'h00;
        m_tmp = 8'h00; m_f = 8'h02; m_res = 8'h00;
        #12;
        // Reset state, including bus released despite flag_rd.
        check("rst_alu_data", alu_data, 8'h00);
        check("rst_flags", flags, 8'h02);
        check("rst_res_valid", {7'd0, res_valid}, 8'h00);
        check("rst_res_wr", {7'd0, res_wr}, 8'h00);
        check("rst_bus", bus, 8'h00);
        flag_rd = 0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // 1: ADD 0xC6 + 0x3A
        cycle(0, 0, 0, 1, 0, 0, 8'h3A);
        cycle(1, 0, 8'hC6, 0, 0, 0, 8'h00);
        check("t1_res", alu_data, 8'h00);
        check("t1_flags", flags, 8'h57);
        check("t1_wr", {7'd0, res_wr}, 8'h01);

        // 2: SUB then CMP 0x05 - 0x07
        cycle(0, 0, 0, 1, 0, 0, 8'h07);
        cycle(1, 2, 8'h05, 0, 0, 0, 8'h00);
        check("t2_sub", alu_data, 8'hFE);
        check("t2_sub_flags", flags, 8'h83);
        cycle(1, 7, 8'h05, 0, 0, 0, 8'h00);
        check("t2_cmp", alu_data, 8'h05);
        check("t2_cmp_wr", {7'd0, res_wr}, 8'h00);

        // 3: ADD giving 0x9B with AC=CY=0, then DAA
        cycle(0, 0, 0, 1, 0, 0, 8'h01);
        cycle(1, 0, 8'h9A, 0, 0, 0, 8'h00);
        check("t3_add_flags", flags, 8'h82);
        cycle(1, 14, 8'h9B, 0, 0, 0, 8'h00);
        check("t3_daa", alu_data, 8'h01);
        check("t3_daa_flags", flags, 8'h13);

        // 4: flag write/read/release
        cycle(0, 0, 0, 0, 1, 0, 8'hFF);
        check("t4_wr", flags, 8'hD7);
        cycle(0, 0, 0, 0, 0, 1, 8'h00);
        check("t4_rd", bus, 8'hD7);
        cycle(0, 0, 0, 0, 0, 0, 8'h00);
        check("t4_release", bus, 8'h00);

        // 5: INR keeps CY; RAR through CY
        cycle(1, 8, 8'hFF, 0, 0, 0, 8'h00);
        check("t5_inr", alu_data, 8'h00);
        check("t5_inr_flags", flags, 8'h57);
        cycle(0, 0, 0, 0, 1, 1, 8'h00);
        check("t5_rdwr_flags", flags, 8'h02);
        cycle(1, 13, 8'h01, 0, 0, 0, 8'h00);
        check("t5_rar", alu_data, 8'h00);
        check("t5_rar_flags", flags, 8'h03);

        // Reserved opcode and flag_wr beating op flags
        cycle(1, 25, 8'h5C, 0, 0, 0, 8'h00);
        check("rsv_res", alu_data, 8'h5C);
        cycle(1, 0, 8'h10, 0, 1, 0, 8'h80);
        check("wr_wins", flags, 8'h82);

        // 6: same-edge TMP load uses old TMP
        cycle(0, 0, 0, 1, 0, 0, 8'h11);
        cycle(1, 0, 8'h20, 1, 0, 0, 8'h22);
        check("t6_old_tmp", alu_data, 8'h31);
        cycle(1, 0, 8'h20, 0, 0, 0, 8'h00);
        check("t6_new_tmp", alu_data, 8'h42);

        // Random back-to-back traffic
        for (int i = 0; i < 600; i++) begin
            int opc;
            bit fr, fw;
            opc = ($urandom % 8 == 0) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
            fw = ($urandom % 8 == 0);
            fr = ($urandom % 4 == 0);
            cycle($urandom % 4 != 0, opc, int'($urandom % 256), $urandom % 3 == 0,
                  fw, fr, int'($urandom % 256));
        end

        // 6b: reset in the middle of a burst
        cycle(1, 4, 8'hF0, 0, 0, 0, 8'h00);
        op_valid = 1; op = 5'd0; acc_in = 8'h33;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_data", alu_data, 8'h00);
        check("mid_rst_flags", flags, 8'h02);
        check("mid_rst_valid", {7'd0, res_valid}, 8'h00);
        @(posedge clk); #1;
        check("hold_rst_valid", {7'd0, res_valid}, 8'h00);
        check("hold_rst_wr", {7'd0, res_wr}, 8'h00);
        op_valid = 0;
        @(negedge clk); reset = 1'b0;
        m_tmp = 8'h00; m_f = 8'h02; m_res = 8'h00;
        @(posedge clk); #1;
        check("post_rst_valid", {7'd0, res_valid}, 8'h00);
        cycle(1, 0, 8'h44, 0, 0, 0, 8'h00);
        check("post_rst_tmp0", alu_data, 8'h44);
        cycle(0, 0, 0, 0, 0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
